// File: rtl/attn_row_score_engine.sv
`default_nettype none
// ============================================================================
// Module      : attn_row_score_engine
// Description : Accumulates N_FEAT signed Q*K products per attention score,
//               buffers N_ROW scaled scores while tracking the row maximum,
//               then streams (score - row_max) saturated to OW bits for the
//               downstream exponent/softmax stage.
// Ports       : clk, rst      - clock, synchronous active-high reset
//               s_q, s_k      - signed Q/K elements (Q0.DW-1)
//               s_vld, s_rdy  - input beat handshake
//               m_score       - saturated score - row_max (never positive)
//               m_max         - saturated row maximum, held during emit
//               m_last        - final score of the row
//               m_vld, m_rdy  - output handshake
// Revision    : 1.0 - initial release
// ============================================================================
module attn_row_score_engine #(
    parameter int DW       = 8,
    parameter int N_FEAT   = 4,
    parameter int N_ROW    = 4,
    parameter int SCALE_SH = 8,
    parameter int OW       = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] s_q,
    input  logic [DW-1:0] s_k,
    input  logic          s_vld,
    output logic          s_rdy,
    output logic [OW-1:0] m_score,
    output logic [OW-1:0] m_max,
    output logic          m_last,
    output logic          m_vld,
    input  logic          m_rdy
);

    localparam int AW = 2*DW + $clog2(N_FEAT);
    localparam int FW = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;
    localparam int RW = (N_ROW  > 1) ? $clog2(N_ROW)  : 1;

    localparam logic [0:0] S_ACCUM = 1'b0;
    localparam logic [0:0] S_EMIT  = 1'b1;

    // Clamp bounds expressed at the AW+1 bit width of the difference path.
    localparam logic signed [AW:0] c_sat_hi = {{(AW-OW+2){1'b0}}, {(OW-1){1'b1}}};
    localparam logic signed [AW:0] c_sat_lo = {{(AW-OW+2){1'b1}}, {(OW-1){1'b0}}};

    function automatic logic [OW-1:0] sat(input logic signed [AW:0] x);
        if (x > c_sat_hi)
            sat = c_sat_hi[OW-1:0];
        else if (x < c_sat_lo)
            sat = c_sat_lo[OW-1:0];
        else
            sat = x[OW-1:0];
    endfunction

    logic [0:0]            r_state;
    logic [0:0]            w_state_next;
    logic signed [AW-1:0]  r_acc;
    logic [FW-1:0]         r_feat_cnt;
    logic [RW-1:0]         r_row_cnt;
    logic [RW-1:0]         r_out_idx;
    logic signed [AW-1:0]  r_row_max;
    logic signed [AW-1:0]  r_score_buf [N_ROW];

    logic signed [2*DW-1:0] w_prod;
    logic signed [AW-1:0]   w_acc_next;
    logic signed [AW-1:0]   w_sc;
    logic signed [AW:0]     w_diff;
    logic signed [AW:0]     w_max_ext;
    logic                   w_beat;
    logic                   w_feat_done;
    logic                   w_row_done;
    logic                   w_out_hs;

    assign w_prod      = $signed(s_q) * $signed(s_k);
    assign w_acc_next  = r_acc + AW'(w_prod);
    // Score includes the product of the beat that completes it.
    assign w_sc        = w_acc_next >>> SCALE_SH;
    assign w_beat      = s_vld & s_rdy;
    assign w_feat_done = w_beat && (r_feat_cnt == FW'(N_FEAT-1));
    assign w_row_done  = w_feat_done && (r_row_cnt == RW'(N_ROW-1));
    assign w_out_hs    = m_vld & m_rdy;
    assign w_max_ext   = $signed({r_row_max[AW-1], r_row_max});
    assign w_diff      = $signed({r_score_buf[r_out_idx][AW-1], r_score_buf[r_out_idx]}) - w_max_ext;

    // State register
    always_ff @(posedge clk) begin
        if (rst)
            r_state <= S_ACCUM;
        else
            r_state <= w_state_next;
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_ACCUM: if (w_row_done)          w_state_next = S_EMIT;
            S_EMIT:  if (w_out_hs && m_last)  w_state_next = S_ACCUM;
            default:                          w_state_next = S_ACCUM;
        endcase
    end

    // Output logic; everything is forced idle while reset is asserted.
    always_comb begin
        s_rdy   = !rst && (r_state == S_ACCUM);
        m_vld   = !rst && (r_state == S_EMIT);
        m_score = '0;
        m_max   = '0;
        m_last  = 1'b0;
        if (m_vld) begin
            m_score = sat(w_diff);
            m_max   = sat(w_max_ext);
            m_last  = (r_out_idx == RW'(N_ROW-1));
        end
    end

    // Accumulator, counters and running maximum
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc      <= '0;
            r_feat_cnt <= '0;
            r_row_cnt  <= '0;
            r_out_idx  <= '0;
            r_row_max  <= '0;
        end else begin
            if (w_beat) begin
                if (w_feat_done) begin
                    r_acc      <= '0;
                    r_feat_cnt <= '0;
                    r_row_cnt  <= w_row_done ? '0 : r_row_cnt + RW'(1);
                    // Strict compare: ties keep the earlier maximum.
                    if ((r_row_cnt == '0) || (w_sc > r_row_max))
                        r_row_max <= w_sc;
                end else begin
                    r_acc      <= w_acc_next;
                    r_feat_cnt <= r_feat_cnt + FW'(1);
                end
            end
            if (w_out_hs)
                r_out_idx <= m_last ? '0 : r_out_idx + RW'(1);
        end
    end

    // Score buffer; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (w_feat_done)
            r_score_buf[r_row_cnt] <= w_sc;
    end

endmodule
`default_nettype wire
